vec_stat_engine: RTL
====================

// Module: vec_stat_engine
// PURPOSE
//  Memory-mapped vector statistics accelerator on the SoC peripheral bus, the parametrised successor to the fixed 8-entry min/max unit.
//  CPU fills a DEPTH-entry data array, sets LEN/mode and writes START.
//  Engine scans one element per cycle and reports MIN, MAX, ARGMIN, ARGMAX and SUM.
//  STATUS.done and irq_o signal completion.
// PARAMETERS
//  BASE_ADDR  32'hC200_0000  base of the register window
//  DEPTH      8              data array entries, power of 2, 2..256
//  W          32             element width, 8..32; elements zero/sign-extended to 32 on read
// PORTS
//  clk_i    in   1   system clock
//  rst_ni   in   1   asynchronous active-low reset
//  en       in   1   bus access enable
//  wr       in   1   1 = write, 0 = read (qualified by en)
//  waddr    in   32  write byte address
//  din      in   32  write data
//  wready   out  1   write acknowledge pulse
//  raddr    in   32  read byte address
//  dout     out  32  read data
//  rready   out  1   read data valid pulse
//  irq_o    out  1   level interrupt = STATUS.done & CTRL.ie
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset values: all outputs 0; array, CTRL, LEN, STATUS and results 0; FSM in IDLE.
//  Address map (offsets from BASE_ADDR, word aligned; addr[1:0] ignored):
//   0x000+4*i  A[i], i<DEPTH, RW
//   0x400 CTRL     RW  [0] start (write-1 pulse, reads 0), [1] signed, [2] ie
//   0x404 LEN      RW  [8:0] elements to scan; 0 -> empty run; >DEPTH clamps to DEPTH
//   0x408 STATUS   RO/W1C  [0] busy (RO), [1] done (sticky, W1C)
//   0x40C MIN, 0x410 MAX, 0x414 ARGMIN, 0x418 ARGMAX  RO
//   0x41C SUM_LO, 0x420 SUM_HI  RO, 64-bit signed/unsigned sum per mode
//  Bus handshake:
//   - Read: address sampled on edge with en&~wr; dout valid and rready=1 for exactly the next cycle, else dout=0.
//   - Write: sampled on edge with en&wr; wready=1 the next cycle.
//   - Unmapped addresses: reads return 0 with an rready pulse; writes are dropped with a wready pulse.
//  FSM states IDLE -> INIT -> SCAN -> COMMIT -> IDLE:
//   - IDLE: a START write with busy=0 sets busy, clears done and latches eff_len = min(LEN,DEPTH) and mode.
//   - INIT: seeds min/max/sum from A[0], idx<=1; goes to SCAN if eff_len>1, else COMMIT.
//   - SCAN: one element per cycle; leaves after idx==eff_len-1.
//   - COMMIT: writes result regs, sets done, clears busy.
//  Latency: done=1 and results visible after edge eff_len+1, where edge 0 samples the START write.
//  LEN=0: INIT skipped; next edge is COMMIT, which writes all results as 0.
//  Compare and sum rules:
//   - signed=1: elements are W-bit two's complement; signed=0: unsigned.
//   - Ties keep the lowest index: update only on strict < (min) or > (max).
//   - SUM accumulates in 64 bits, sign- or zero-extended per mode.
//  Busy conditions:
//   - Array or LEN writes while busy are dropped, wready still pulses.
//   - START while busy is ignored.
//   - Result regs hold previous values until COMMIT.
//  Simultaneous events:
//   - W1C of done in the same cycle as COMMIT: done ends at 1 (set wins).
//   - START while done=1: done is cleared and a new run begins.
//  Reset mid-run: immediate return to IDLE with all state cleared; no done and no irq.
//  Read of a result reg during COMMIT edge returns the old value; the next read returns the new one.
// STRUCTURE
//  vec_stat_pkg holds:
//   - register offset localparams
//   - CTRL/STATUS bit positions
//   - FSM state encoding (IDLE/INIT/SCAN/COMMIT)
//   - clog2 helper function
//  Sub-module vec_stat_dp: running min/max/argmin/argmax/64-bit sum datapath.
//   - inputs: seed, step, element, idx, signed
//   - The top holds the bus decode, register file, array and FSM.
// TESTING
//  - Reset, then read 0x40C..0x420 -> all 0 with one rready pulse each; unmapped read 0x500 -> dout=0, rready=1.
//  - DEPTH=8, A={5,-3,7,-3,0,7,2,1}, LEN=8, signed=1, START:
//    - MIN=-3 (0xFFFFFFFD), ARGMIN=1, MAX=7, ARGMAX=2, SUM_LO=16, SUM_HI=0.
//    - done exactly at edge 9.
//  - Same data with signed=0 -> MAX=0xFFFFFFFD, ARGMAX=1, MIN=0, ARGMIN=4, SUM_LO=16, SUM_HI=2.
//  - LEN=3 then LEN=0 then LEN=20 (clamps to 8):
//    - LEN=3: results over A[0..2].
//    - LEN=0: all results 0 with done after edge 1.
//    - LEN=20: results equal the LEN=8 run.
//  - During busy: write A[0]=100 and START again -> both ignored, wready pulses, results reflect original data.
//  - With ie=1, irq_o rises with done; W1C in the COMMIT cycle leaves done=1.
//  - With ie=1: assert rst_ni low mid-SCAN -> busy=0, done=0, irq_o=0 immediately.

Source files
------------

// File: rtl/vec_stat_pkg.sv
// Shared definitions for the vector statistics engine: register map,
// control/status bit positions, FSM encoding and a constant log2 helper.
package vec_stat_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h400;
    localparam logic [31:0] OFF_LEN    = 32'h404;
    localparam logic [31:0] OFF_STATUS = 32'h408;
    localparam logic [31:0] OFF_MIN    = 32'h40C;
    localparam logic [31:0] OFF_MAX    = 32'h410;
    localparam logic [31:0] OFF_ARGMIN = 32'h414;
    localparam logic [31:0] OFF_ARGMAX = 32'h418;
    localparam logic [31:0] OFF_SUM_LO = 32'h41C;
    localparam logic [31:0] OFF_SUM_HI = 32'h420;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IE     = 2;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    localparam int LEN_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_stat_dp.sv
// Running min/max/argmin/argmax and 64-bit sum over a stream of elements.
// Seed loads the first element; each step folds in one more.
module vec_stat_dp
    import vec_stat_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_seed,
    input  logic          i_step,
    input  logic          i_signed,
    input  logic [W-1:0]  i_elem,
    input  logic [AW-1:0] i_idx,
    output logic [31:0]   o_min,
    output logic [31:0]   o_max,
    output logic [AW-1:0] o_argmin,
    output logic [AW-1:0] o_argmax,
    output logic [63:0]   o_sum
);

    logic [W-1:0]        r_min;
    logic [W-1:0]        r_max;
    logic [AW-1:0]       r_argmin;
    logic [AW-1:0]       r_argmax;
    logic [63:0]         r_sum;

    logic signed [W-1:0] w_elem_s;
    logic signed [W-1:0] w_min_s;
    logic signed [W-1:0] w_max_s;
    logic                w_lt;
    logic                w_gt;
    logic [63:0]         w_elem_ext;

    assign w_elem_s = i_elem;
    assign w_min_s  = r_min;
    assign w_max_s  = r_max;

    // Strict compares so ties keep the earliest index.
    assign w_lt = i_signed ? (w_elem_s < w_min_s) : (i_elem < r_min);
    assign w_gt = i_signed ? (w_elem_s > w_max_s) : (i_elem > r_max);

    assign w_elem_ext = i_signed ? 64'(w_elem_s) : 64'(i_elem);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_min    <= '0;
            r_max    <= '0;
            r_argmin <= '0;
            r_argmax <= '0;
            r_sum    <= '0;
        end else if (i_seed) begin
            r_min    <= i_elem;
            r_max    <= i_elem;
            r_argmin <= i_idx;
            r_argmax <= i_idx;
            r_sum    <= w_elem_ext;
        end else if (i_step) begin
            if (w_lt) begin
                r_min    <= i_elem;
                r_argmin <= i_idx;
            end
            if (w_gt) begin
                r_max    <= i_elem;
                r_argmax <= i_idx;
            end
            r_sum <= r_sum + w_elem_ext;
        end
    end

    assign o_min    = i_signed ? 32'(w_min_s) : 32'(r_min);
    assign o_max    = i_signed ? 32'(w_max_s) : 32'(r_max);
    assign o_argmin = r_argmin;
    assign o_argmax = r_argmax;
    assign o_sum    = r_sum;

endmodule

// File: rtl/vec_stat_engine.sv
// Memory-mapped vector statistics engine: bus decode, register file, data
// array and the scan sequencer around the vec_stat_dp datapath.
//
// state  | meaning
// IDLE   | waiting for START; registers freely writable
// INIT   | seed datapath from A[0], idx <= 1
// SCAN   | fold in A[idx], one element per cycle
// COMMIT | copy datapath to result regs, set done, drop busy
module vec_stat_engine
    import vec_stat_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hC200_0000,
    parameter int          DEPTH     = 8,
    parameter int          W         = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en,
    input  logic        wr,
    input  logic [31:0] waddr,
    input  logic [31:0] din,
    output logic        wready,
    input  logic [31:0] raddr,
    output logic [31:0] dout,
    output logic        rready,
    output logic        irq_o
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t              r_state;
    state_t              w_next;

    logic [W-1:0]        r_mem [DEPTH];
    logic [LEN_W-1:0]    r_len;
    logic                r_cfg_signed;
    logic                r_ie;
    logic                r_mode;
    logic                r_done;
    logic [LW-1:0]       r_eff_len;
    logic [LW-1:0]       r_idx;
    logic [31:0]         r_min;
    logic [31:0]         r_max;
    logic [31:0]         r_argmin;
    logic [31:0]         r_argmax;
    logic [63:0]         r_sum;
    logic                r_wready;
    logic                r_rready;
    logic [31:0]         r_dout;

    logic                w_wr_en;
    logic                w_rd_en;
    logic [31:0]         w_woff;
    logic [31:0]         w_roff;
    logic                w_warr;
    logic                w_rarr;
    logic [AW-1:0]       w_widx;
    logic [AW-1:0]       w_ridx;
    logic [AW-1:0]       w_cur_idx;
    logic [LW-1:0]       w_len_clamp;
    logic                w_start;
    logic                w_w1c;
    logic                w_busy;
    logic                w_seed;
    logic                w_step;
    logic                w_commit;
    logic [W-1:0]        w_elem_rd;
    logic signed [W-1:0] w_elem_rd_s;
    logic [31:0]         w_rdata;
    logic [31:0]         w_dp_min;
    logic [31:0]         w_dp_max;
    logic [AW-1:0]       w_dp_argmin;
    logic [AW-1:0]       w_dp_argmax;
    logic [63:0]         w_dp_sum;
    logic                w_unused;

    assign w_wr_en = en & wr;
    assign w_rd_en = en & ~wr;

    assign w_woff = (waddr - BASE_ADDR) & ~32'h3;
    assign w_roff = (raddr - BASE_ADDR) & ~32'h3;
    assign w_warr = w_woff < 32'(4 * DEPTH);
    assign w_rarr = w_roff < 32'(4 * DEPTH);
    assign w_widx = w_woff[AW+1:2];
    assign w_ridx = w_roff[AW+1:2];

    assign w_len_clamp = (r_len > LEN_W'(DEPTH)) ? LW'(DEPTH) : LW'(r_len);

    assign w_start = w_wr_en && (w_woff == OFF_CTRL) && din[CTRL_START] && !w_busy;
    assign w_w1c   = w_wr_en && (w_woff == OFF_STATUS) && din[STAT_DONE];

    assign w_unused = &{1'b0, din[31:LEN_W]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = (w_len_clamp == '0) ? ST_COMMIT : ST_INIT;
            ST_INIT:   w_next = (r_eff_len > LW'(1)) ? ST_SCAN : ST_COMMIT;
            ST_SCAN:   if (r_idx == r_eff_len - LW'(1)) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        w_seed    = (r_state == ST_INIT);
        w_step    = (r_state == ST_SCAN);
        w_commit  = (r_state == ST_COMMIT);
        w_cur_idx = w_seed ? '0 : r_idx[AW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eff_len <= '0;
            r_mode    <= 1'b0;
            r_idx     <= '0;
        end else if (w_start) begin
            r_eff_len <= w_len_clamp;
            r_mode    <= din[CTRL_SIGNED];
            r_idx     <= '0;
        end else if (w_seed) begin
            r_idx <= LW'(1);
        end else if (w_step) begin
            r_idx <= r_idx + LW'(1);
        end
    end

    // Completion beats a same-cycle W1C so software never loses a done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                r_done <= 1'b0;
        else if (w_commit)          r_done <= 1'b1;
        else if (w_start || w_w1c)  r_done <= 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg_signed <= 1'b0;
            r_ie         <= 1'b0;
            r_len        <= '0;
        end else if (w_wr_en) begin
            if (w_woff == OFF_CTRL) begin
                r_cfg_signed <= din[CTRL_SIGNED];
                r_ie         <= din[CTRL_IE];
            end
            if ((w_woff == OFF_LEN) && !w_busy) r_len <= din[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en && w_warr && !w_busy) begin
            r_mem[w_widx] <= din[W-1:0];
        end
    end

    vec_stat_dp #(
        .W  (W),
        .AW (AW)
    ) u_dp (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_seed   (w_seed),
        .i_step   (w_step),
        .i_signed (r_mode),
        .i_elem   (r_mem[w_cur_idx]),
        .i_idx    (w_cur_idx),
        .o_min    (w_dp_min),
        .o_max    (w_dp_max),
        .o_argmin (w_dp_argmin),
        .o_argmax (w_dp_argmax),
        .o_sum    (w_dp_sum)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_min    <= '0;
            r_max    <= '0;
            r_argmin <= '0;
            r_argmax <= '0;
            r_sum    <= '0;
        end else if (w_commit) begin
            if (r_eff_len == '0) begin
                r_min    <= '0;
                r_max    <= '0;
                r_argmin <= '0;
                r_argmax <= '0;
                r_sum    <= '0;
            end else begin
                r_min    <= w_dp_min;
                r_max    <= w_dp_max;
                r_argmin <= 32'(w_dp_argmin);
                r_argmax <= 32'(w_dp_argmax);
                r_sum    <= w_dp_sum;
            end
        end
    end

    assign w_elem_rd   = r_mem[w_ridx];
    assign w_elem_rd_s = w_elem_rd;

    always_comb begin
        w_rdata = '0;
        if (w_rarr) begin
            w_rdata = r_cfg_signed ? 32'(w_elem_rd_s) : 32'(w_elem_rd);
        end else begin
            case (w_roff)
                OFF_CTRL:   w_rdata = {29'b0, r_ie, r_cfg_signed, 1'b0};
                OFF_LEN:    w_rdata = {{(32-LEN_W){1'b0}}, r_len};
                OFF_STATUS: w_rdata = {30'b0, r_done, w_busy};
                OFF_MIN:    w_rdata = r_min;
                OFF_MAX:    w_rdata = r_max;
                OFF_ARGMIN: w_rdata = r_argmin;
                OFF_ARGMAX: w_rdata = r_argmax;
                OFF_SUM_LO: w_rdata = r_sum[31:0];
                OFF_SUM_HI: w_rdata = r_sum[63:32];
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wready <= 1'b0;
            r_rready <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_wready <= w_wr_en;
            r_rready <= w_rd_en;
            r_dout   <= w_rd_en ? w_rdata : '0;
        end
    end

    assign wready = r_wready;
    assign rready = r_rready;
    assign dout   = r_dout;
    assign irq_o  = r_done & r_ie;

endmodule
